psram_ctrl: RTL and testbench

Host-side QPI controller for the serial PSRAM device on the `sck`/`ce_n`/`dio` bus. It accepts single-word read and byte/halfword/word write requests on a valid/ready interface and serialises them as EBh (quad read) and 38h (quad write) transactions. After reset it automatically issues 35h in SPI mode to move the device into QPI mode. It sits between the SoC memory bridge and the top-level PSRAM pad wrapper, which builds the `dio` tristate from `dio_o`/`dio_oe`/`dio_i`.

---
 rtl/psram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_psram_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_ctrl.sv
// QPI PSRAM host controller: boots the device into QPI with 35h, then serves
// single-word EBh reads and byte/halfword/word 38h writes over a valid/ready pair.
module psram_ctrl #(
    parameter int DUMMY_BEATS   = 6,
    parameter int CS_HIGH_BEATS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dio_o,
    output logic        dio_oe,
    input  logic [3:0]  dio_i
);
    typedef enum logic [3:0] {INIT, IDLE, CMD, ADDR, WAIT, RDATA, WDATA, CSH, RESP} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n, last;
    logic        ph, ph_n;
    logic        booted, booted_n;
    logic        started;
    logic        cap_we, cap_we_n;
    logic [23:0] cap_addr, cap_addr_n;
    logic [1:0]  cap_size, cap_size_n;
    logic [31:0] cap_wdata, cap_wdata_n;
    logic        accept, reject;
    logic        sck_d, ce_n_d, oe_d;
    logic [3:0]  dio_d;
    logic [7:0]  op, wbyte;
    logic [1:0]  lane;

    assign reject = req_we ? (req_size == 2'd3 ||
                              (req_size == 2'd1 && req_addr[0]) ||
                              (req_size == 2'd2 && req_addr[1:0] != 2'd0))
                           : (req_addr[1:0] != 2'd0);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        ph_n        = ph;
        booted_n    = booted;
        accept      = 1'b0;
        cap_we_n    = cap_we;
        cap_addr_n  = cap_addr;
        cap_size_n  = cap_size;
        cap_wdata_n = cap_wdata;
        case (state)
            INIT:    last = 8'd7;
            CMD:     last = 8'd1;
            ADDR:    last = 8'd5;
            WAIT:    last = 8'(DUMMY_BEATS - 1);
            RDATA:   last = 8'd7;
            WDATA:   last = (8'd2 << cap_size) - 8'd1;
            CSH:     last = 8'(CS_HIGH_BEATS - 1);
            default: last = 8'd0;
        endcase
        // One idle cycle after reset so the first INIT beat gets its full sck-low half.
        if (!started) begin
            state_n = INIT;
            cnt_n   = 8'd0;
            ph_n    = 1'b0;
        end else if (state inside {INIT, CMD, ADDR, WAIT, RDATA, WDATA, CSH}) begin
            ph_n = ~ph;
            if (ph) begin
                if (cnt == last) begin
                    cnt_n = 8'd0;
                    case (state)
                        INIT:         state_n = CSH;
                        CMD:          state_n = ADDR;
                        ADDR:         state_n = cap_we ? WDATA : WAIT;
                        WAIT:         state_n = RDATA;
                        RDATA, WDATA: state_n = CSH;
                        CSH: begin
                            state_n  = booted ? RESP : IDLE;
                            booted_n = 1'b1;
                        end
                        default:      state_n = state;
                    endcase
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
        end else if (state == IDLE) begin
            if (req_valid) begin
                accept      = 1'b1;
                cap_we_n    = req_we;
                cap_addr_n  = req_addr;
                cap_size_n  = req_size;
                cap_wdata_n = req_wdata;
                state_n     = reject ? RESP : CMD;
                cnt_n       = 8'd0;
                ph_n        = 1'b0;
            end
        end else if (state == RESP && resp_ready) begin
            state_n = IDLE;
        end
    end

    // Pad outputs are registered from the next state, so they line up with the state register.
    always_comb begin
        op     = cap_we_n ? 8'h38 : 8'hEB;
        lane   = cap_addr_n[1:0] + cnt_n[2:1];
        wbyte  = 8'(cap_wdata_n >> {lane, 3'b000});
        sck_d  = 1'b0;
        ce_n_d = 1'b1;
        oe_d   = 1'b0;
        dio_d  = 4'h0;
        case (state_n)
            INIT, CMD, ADDR, WDATA: begin
                sck_d  = ph_n;
                ce_n_d = 1'b0;
                oe_d   = 1'b1;
                case (state_n)
                    INIT:    dio_d = {3'b000, 1'(8'h35 >> (3'd7 - cnt_n[2:0]))};
                    CMD:     dio_d = cnt_n[0] ? op[3:0] : op[7:4];
                    ADDR:    dio_d = 4'(cap_addr_n >> (5'd20 - {cnt_n[2:0], 2'b00}));
                    default: dio_d = cnt_n[0] ? wbyte[3:0] : wbyte[7:4];
                endcase
            end
            WAIT, RDATA: begin
                sck_d  = ph_n;
                ce_n_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            cnt        <= 8'd0;
            ph         <= 1'b0;
            booted     <= 1'b0;
            started    <= 1'b0;
            cap_we     <= 1'b0;
            cap_addr   <= 24'd0;
            cap_size   <= 2'd0;
            cap_wdata  <= 32'd0;
            sck        <= 1'b0;
            ce_n       <= 1'b1;
            dio_oe     <= 1'b0;
            dio_o      <= 4'h0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ph         <= ph_n;
            booted     <= booted_n;
            started    <= 1'b1;
            cap_we     <= cap_we_n;
            cap_addr   <= cap_addr_n;
            cap_size   <= cap_size_n;
            cap_wdata  <= cap_wdata_n;
            sck        <= sck_d;
            ce_n       <= ce_n_d;
            dio_oe     <= oe_d;
            dio_o      <= dio_d;
            req_ready  <= (state_n == IDLE);
            resp_valid <= (state_n == RESP);
            if (accept) begin
                resp_rdata <= 32'd0;
                resp_err   <= reject;
            end else if (state == RDATA && !ph) begin
                // Sample on the edge that raises sck; nibble k lands high-first within byte k/2.
                resp_rdata[{cnt[2:1], ~cnt[0], 2'b00} +: 4] <= dio_i;
            end
        end
    end
endmodule

// File: tb/tb_psram_ctrl.sv
// Bench for psram_ctrl: bus monitor with a PSRAM device model, directed vector
// table, randomized requests against a byte-array reference, and reset corner cases.
module tb_psram_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [23:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_rdata;
    logic        sck, ce_n, dio_oe;
    logic [3:0]  dio_o;
    logic [3:0]  dio_i = 4'h0;

    always #5 clock = ~clock;

    psram_ctrl dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .sck(sck), .ce_n(ce_n), .dio_o(dio_o), .dio_oe(dio_oe), .dio_i(dio_i)
    );

    int npass = 0, nchk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] preload(int a);
        case (a)
            256: return 8'h11;
            257: return 8'h22;
            258: return 8'h33;
            259: return 8'h44;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- bus monitor + device model ----------------
    logic [4:0] q[$], last_q[$];
    int         low_cnt = 0, last_low = 0, ntx = 0, mon_a, mon_idx;
    logic       prev_ce = 1'b1, prev_sck = 1'b0;
    logic [7:0] mon_b;
    logic [7:0] dev_mem[int];

    function automatic logic [7:0] dev_rd(int a);
        return dev_mem.exists(a) ? dev_mem[a] : preload(a);
    endfunction

    always @(negedge clock) begin
        if (!ce_n) begin
            if (prev_ce) begin
                q.delete();
                low_cnt = 0;
            end
            low_cnt++;
            if (sck && !prev_sck) q.push_back({dio_oe, dio_o});
            if (!sck) begin
                mon_idx = q.size();
                if (mon_idx >= 14 && mon_idx < 22 && q[0][3:0] == 4'hE && q[1][3:0] == 4'hB) begin
                    mon_a = 0;
                    for (int i = 2; i < 8; i++) mon_a = (mon_a << 4) | int'(q[i][3:0]);
                    mon_b = dev_rd(mon_a + (mon_idx - 14) / 2);
                    dio_i = ((mon_idx - 14) % 2 == 0) ? mon_b[7:4] : mon_b[3:0];
                end else begin
                    dio_i = 4'($urandom);
                end
            end
        end else if (!prev_ce) begin
            last_q   = q;
            last_low = low_cnt;
            ntx++;
            if (q.size() >= 10 && q[0][3:0] == 4'h3 && q[1][3:0] == 4'h8) begin
                mon_a = 0;
                for (int i = 2; i < 8; i++) mon_a = (mon_a << 4) | int'(q[i][3:0]);
                for (int j = 0; j < (q.size() - 8) / 2; j++)
                    dev_mem[mon_a + j] = {q[8 + 2 * j][3:0], q[9 + 2 * j][3:0]};
            end
        end
        prev_ce  = ce_n;
        prev_sck = sck;
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem[int];

    function automatic logic [7:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : preload(a);
    endfunction

    function automatic logic m_err(logic we, int a, int size);
        if (!we) return (a % 4) != 0;
        if (size == 3) return 1'b1;
        return (a % (1 << size)) != 0;
    endfunction

    // Applies the model to one request; returns expected err/rdata/ce-low clocks.
    task automatic model(input logic we, input int a, input int size, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd, output int low);
        err = m_err(we, a, size);
        rd  = 32'd0;
        low = 0;
        if (err) return;
        if (we) begin
            for (int j = 0; j < (1 << size); j++) ref_mem[a + j] = wd[8 * ((a % 4) + j) +: 8];
            low = (8 + 2 * (1 << size)) * 2;
        end else begin
            rd  = {ref_rd(a + 3), ref_rd(a + 2), ref_rd(a + 1), ref_rd(a)};
            low = (2 + 6 + 6 + 8) * 2;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_req(input logic we, input logic [23:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int low, output int oe0, output int tx);
        int tx0 = ntx;
        @(negedge clock);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clock);
        chk("req_ready_wait", req_ready, 1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_wdata = $urandom; req_addr = 24'($urandom); req_size = 2'($urandom); req_we = 1'($urandom);
        lat = 1;
        low = 0;
        while (!resp_valid && lat < 200) begin
            if (!ce_n) low++;
            @(negedge clock);
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("hold_stable", {resp_valid, resp_err, req_ready, resp_rdata}, {1'b1, err, 1'b0, rdata});
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        chk("turnaround", {req_ready, resp_valid}, 2'b10);
        oe0 = 0;
        foreach (last_q[i]) if (!last_q[i][4]) oe0++;
        tx = ntx - tx0;
    endtask

    task automatic check_init(input string tag);
        int hi = 0, tx0 = ntx;
        bit seen = 0, rv = 0, ok = 0;
        logic [7:0] seq = '0, oe = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (resp_valid) rv = 1;
            if (req_ready) begin ok = 1; break; end
            if (!ce_n) seen = 1;
            else if (seen) hi++;
        end
        chk({tag, "_ready"}, ok, 1);
        chk({tag, "_no_resp"}, rv, 0);
        chk({tag, "_csh_clocks"}, hi, 2);
        chk({tag, "_tx"}, ntx - tx0, 1);
        chk({tag, "_ce_low"}, last_low, 16);
        chk({tag, "_beats"}, last_q.size(), 8);
        for (int i = 0; i < 8 && i < last_q.size(); i++) begin
            seq = {seq[6:0], last_q[i][0]};
            oe  = {oe[6:0], last_q[i][4]};
        end
        chk({tag, "_35h"}, seq, 8'h35);
        chk({tag, "_oe"}, oe, 8'hFF);
    endtask

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        int          hold;
        logic        err;
        logic [31:0] rdata;
        int          low;
        int          nnib;
        logic [63:0] nib;
    } vec_t;

    vec_t        vt[9];
    logic [31:0] rd, m_rd;
    logic        er, m_er;
    int          lat, low, oe0, tx, m_low;
    logic [63:0] got;

    initial begin
        vt[0] = '{0, 24'h000100, 2'd0, 32'h0,        0, 0, 32'h44332211, 44, 8,  64'hEB000100};
        vt[1] = '{1, 24'h000010, 2'd2, 32'hAABBCCDD, 0, 0, 32'h0,        32, 16, 64'h38000010DDCCBBAA};
        vt[2] = '{1, 24'h000003, 2'd0, 32'h12345678, 0, 0, 32'h0,        20, 10, 64'h3800000312};
        vt[3] = '{1, 24'h000001, 2'd1, 32'hDEADBEEF, 5, 1, 32'h0,        0,  0,  64'h0};
        vt[4] = '{1, 24'h000000, 2'd3, 32'h01020304, 0, 1, 32'h0,        0,  0,  64'h0};
        vt[5] = '{0, 24'h000002, 2'd0, 32'h0,        2, 1, 32'h0,        0,  0,  64'h0};
        vt[6] = '{1, 24'h000012, 2'd1, 32'h55667788, 0, 0, 32'h0,        24, 0,  64'h0};
        vt[7] = '{0, 24'h000010, 2'd0, 32'h0,        0, 0, 32'h5566CCDD, 44, 0,  64'h0};
        vt[8] = '{0, 24'h000000, 2'd0, 32'h0,        0, 0, 32'h12000000, 44, 0,  64'h0};

        repeat (3) @(negedge clock);
        chk("rst_ce_n", ce_n, 1);
        chk("rst_sck", sck, 0);
        chk("rst_oe", dio_oe, 0);
        chk("rst_dio", dio_o, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
        reset = 1'b0;
        check_init("boot");

        foreach (vt[i]) begin
            do_req(vt[i].we, vt[i].addr, vt[i].size, vt[i].wdata, vt[i].hold, rd, er, lat, low, oe0, tx);
            model(vt[i].we, int'(vt[i].addr), int'(vt[i].size), vt[i].wdata, m_er, m_rd, m_low);
            chk($sformatf("vec%0d_err", i), er, vt[i].err);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d_ce_low", i), low, vt[i].low);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].err ? 1 : vt[i].low + 3);
            chk($sformatf("vec%0d_tx", i), tx, vt[i].err ? 0 : 1);
            if (!vt[i].err) chk($sformatf("vec%0d_oe0", i), oe0, vt[i].we ? 0 : 14);
            if (vt[i].nnib > 0) begin
                got = '0;
                for (int k = 0; k < vt[i].nnib && k < last_q.size(); k++) got = (got << 4) | 64'(last_q[k][3:0]);
                chk($sformatf("vec%0d_nibbles", i), got, vt[i].nib);
            end
        end

        for (int n = 0; n < 40; n++) begin
            logic        we = 1'($urandom);
            logic [1:0]  sz = 2'($urandom);
            logic [23:0] ad = 24'($urandom_range(0, 63));
            logic [31:0] wd = $urandom;
            do_req(we, ad, sz, wd, 0, rd, er, lat, low, oe0, tx);
            model(we, int'(ad), int'(sz), wd, m_er, m_rd, m_low);
            chk($sformatf("rnd%0d_err", n), er, m_er);
            chk($sformatf("rnd%0d_rdata", n), rd, m_rd);
            chk($sformatf("rnd%0d_ce_low", n), low, m_low);
            chk($sformatf("rnd%0d_lat", n), lat, m_er ? 1 : m_low + 3);
        end

        // Reset while the read data phase is in progress.
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000100;
        for (int i = 0; i < 200 && !req_ready; i++) @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (33) @(negedge clock);
        chk("mid_read_active", {ce_n, dio_oe, resp_valid}, 3'b000);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_async", {ce_n, dio_oe, sck, resp_valid}, 4'b1000);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_init("rerun");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
